wr_err_responder: RTL and testbench
===================================

# wr_err_responder

Write-channel error responder that terminates AXI write traffic on the master side of the monitor while the write guard holds the subordinate in isolation. It is enabled by the guard's reset request. While enabled it accepts AW requests, sinks every W beat and returns one SLVERR B response per transaction, in order. It also completes write transactions that were orphaned when the subordinate stopped responding; the guard loads these through a side port.

## Interface
Parameters:
- MaxWrTxns, 32, depth of the internal transaction queue (≥1, any value; not restricted to powers of two).
- IdWidth, 4, AXI ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- isolate_i  in  1  takeover enable, driven by the write guard's reset request.
- pend_valid_i  in  1  orphaned transaction push valid.
- pend_ready_o  out  1  orphan push ready.
- pend_id_i  in  IdWidth  orphan ID.
- pend_len_i  in  8  orphan remaining beats minus one.
- pend_wdone_i  in  1  orphan W data already fully transferred.
- aw_valid_i / aw_ready_o  in/out  1  AW handshake.
- aw_id_i  in  IdWidth  AW ID.
- aw_len_i  in  8  AW burst length minus one.
- w_valid_i / w_ready_o  in/out  1  W handshake.
- w_last_i  in  1  W last flag.
- b_valid_o / b_ready_i  out/in  1  B handshake.
- b_id_o  out  IdWidth  B ID.
- b_resp_o  out  2  B response; always 2'b10 (SLVERR) when b_valid_o is high, otherwise 0.
- busy_o  out  1  FSM is not IDLE.
- proto_err_o  out  1  one-cycle pulse on a w_last mismatch.

## Operation
Queue:
- Circular buffer of MaxWrTxns entries. Each entry holds {id, len, beat_cnt, w_done}.
- Pointers: wr_ptr for push, w_ptr for the entry currently receiving W data, b_ptr for pop.
- All pointers wrap explicitly from MaxWrTxns-1 to 0.
- occupancy counter has width $clog2(MaxWrTxns+1).

FSM states:
- IDLE: all readies and b_valid_o are 0.
  - Moves to ACTIVE when isolate_i=1.
- ACTIVE: accepts pushes from both sources, drains W, issues B.
  - Moves to DRAIN when isolate_i=0 and occupancy≠0.
  - Moves to IDLE when isolate_i=0 and occupancy=0.
- DRAIN: aw_ready_o=0 and pend_ready_o=0; W draining and B issue continue.
  - Moves to IDLE when occupancy=0.
  - Moves to ACTIVE if isolate_i rises again.

Push rules:
- At most one push per cycle.
- pend_ready_o = ACTIVE && occupancy<MaxWrTxns.
- aw_ready_o = pend_ready_o && !pend_valid_i. Orphans have priority over new AW.
- Fullness is judged on registered occupancy. A pop in the same cycle does not enable a push.
- A pushed entry has beat_cnt=0 and w_done=pend_wdone_i for orphans, 0 for AW.

W drain:
- w_ready_o=1 when state≠IDLE, w_ptr≠wr_ptr (or the queue is full), and entry[w_ptr].w_done=0.
- If entry[w_ptr].w_done=1, w_ptr advances without waiting for any beat.
- On each W handshake beat_cnt increments.
- The beat where beat_cnt==len sets w_done and advances w_ptr.
- If w_last_i ≠ (beat_cnt==len) on a handshake, proto_err_o pulses. The beat count alone decides completion.

B issue:
- b_valid_o=1 when occupancy≠0 and entry[b_ptr].w_done=1.
- b_id_o = entry[b_ptr].id.
- b_valid_o, b_id_o and b_resp_o stay stable until b_ready_i. Then b_ptr advances and occupancy decrements.
- Responses leave strictly in push order.

## Timing
- Reset: every output is 0. The FSM is IDLE, pointers and occupancy are 0, and all entries are cleared.
- Reset asserted mid-transaction discards every entry immediately, including a B held with b_valid_o high.
- IDLE→ACTIVE takes 1 cycle: readies can first be high in the cycle after isolate_i is sampled high.
- An AW accepted in cycle N is visible to W drain in N+1, so w_ready_o can be high in N+1.
- w_done is registered. b_valid_o rises the cycle after the final W handshake.
- Minimum latency for len=0 is AW at N, W at N+1, B at N+2.
- An orphan with pend_wdone_i=1 pushed at N as the only entry has b_valid_o=1 at N+1.
- Push and pop in the same cycle leave occupancy unchanged.
- Pop while full: the freed slot becomes available the next cycle.

## Test plan
- Reset, then isolate_i=1; AW id=3 len=0 at cycle N; W with last=1 at N+1 → b_valid_o at N+2 with b_id_o=3, b_resp_o=2'b10. Hold b_ready_i=0 for 4 cycles → outputs stable throughout.
- Push orphans id=1 (wdone=1) and id=2 (wdone=0, len=3) plus AW id=5 len=1. Send 4+2 W beats → B order is 1, 2, 5. The AW is stalled while pend_valid_i is high.
- With MaxWrTxns=3, push 3 AWs and hold b_ready_i=0 → aw_ready_o=0 and pend_ready_o=0. One B handshake → aw_ready_o=1 the following cycle. Pointers wrap correctly over 10 rounds.
- AW len=2 with w_last_i=1 on beat 0 → proto_err_o pulses once; the entry still waits for 3 beats before its B.
- Drop isolate_i with 2 entries pending → state DRAIN, aw_ready_o=0, both B responses issued, then busy_o=0.
- Assert rst_i while b_valid_o=1 → all outputs 0 immediately. After reset release with isolate_i=1, no stale B is issued.

Source files
------------

// File: rtl/wr_err_responder.sv
//------------------------------------------------------------------------------
// Module   : wr_err_responder
// Summary  : Terminates AXI write traffic with in-order SLVERR B responses
//            while the subordinate is isolated by the write guard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wr_err_responder #(
   parameter int MaxWrTxns = 32,
   parameter int IdWidth   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               isolate_i,
   input  logic               pend_valid_i,
   output logic               pend_ready_o,
   input  logic [IdWidth-1:0] pend_id_i,
   input  logic [7:0]         pend_len_i,
   input  logic               pend_wdone_i,
   input  logic               aw_valid_i,
   output logic               aw_ready_o,
   input  logic [IdWidth-1:0] aw_id_i,
   input  logic [7:0]         aw_len_i,
   input  logic               w_valid_i,
   output logic               w_ready_o,
   input  logic               w_last_i,
   output logic               b_valid_o,
   input  logic               b_ready_i,
   output logic [IdWidth-1:0] b_id_o,
   output logic [1:0]         b_resp_o,
   output logic               busy_o,
   output logic               proto_err_o
);

   localparam int c_PW = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
   localparam int c_OW = $clog2(MaxWrTxns + 1);
   localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(MaxWrTxns - 1);
   localparam logic [c_OW-1:0] c_FULL_OCC = c_OW'(MaxWrTxns);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   state_t             r_state;
   logic [IdWidth-1:0] r_id    [MaxWrTxns];
   logic [7:0]         r_len   [MaxWrTxns];
   logic [7:0]         r_cnt   [MaxWrTxns];
   logic               r_wdone [MaxWrTxns];
   logic [c_PW-1:0]    r_wr_ptr;
   logic [c_PW-1:0]    r_w_ptr;
   logic [c_PW-1:0]    r_b_ptr;
   logic [c_OW-1:0]    r_occ;
   logic [c_OW-1:0]    r_wpend;
   logic               r_proto_err;

   logic            w_full;
   logic            w_pend_ready;
   logic            w_aw_ready;
   logic            w_push_pend;
   logic            w_push_aw;
   logic            w_push;
   logic            w_cur_done;
   logic            w_w_avail;
   logic            w_w_ready;
   logic            w_w_hs;
   logic            w_last_beat;
   logic            w_w_adv;
   logic            w_b_valid;
   logic            w_pop;
   logic [c_OW-1:0] w_occ_nxt;

   function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
      return (p == c_LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign w_full       = (r_occ == c_FULL_OCC);
   assign w_pend_ready = (r_state == S_ACTIVE) && !w_full;
   assign w_aw_ready   = w_pend_ready && !pend_valid_i;
   assign w_push_pend  = pend_valid_i && w_pend_ready;
   assign w_push_aw    = aw_valid_i && w_aw_ready;
   assign w_push       = w_push_pend || w_push_aw;

   // r_wpend counts entries not yet passed by w_ptr; it disambiguates
   // w_ptr == wr_ptr between "nothing to drain" and "full, all undrained".
   assign w_cur_done  = r_wdone[r_w_ptr];
   assign w_w_avail   = (r_state != S_IDLE) && (r_wpend != '0);
   assign w_w_ready   = w_w_avail && !w_cur_done;
   assign w_w_hs      = w_w_ready && w_valid_i;
   assign w_last_beat = (r_cnt[r_w_ptr] == r_len[r_w_ptr]);
   assign w_w_adv     = w_w_avail && (w_cur_done || (w_valid_i && w_last_beat));

   assign w_b_valid = (r_occ != '0) && r_wdone[r_b_ptr];
   assign w_pop     = w_b_valid && b_ready_i;
   assign w_occ_nxt = r_occ + c_OW'(w_push) - c_OW'(w_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_w_ptr     <= '0;
         r_b_ptr     <= '0;
         r_occ       <= '0;
         r_wpend     <= '0;
         r_proto_err <= 1'b0;
         for (int i = 0; i < MaxWrTxns; i++) begin
            r_id[i]    <= '0;
            r_len[i]   <= '0;
            r_cnt[i]   <= '0;
            r_wdone[i] <= 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE:   if (isolate_i) r_state <= S_ACTIVE;
            S_ACTIVE: if (!isolate_i) r_state <= (w_occ_nxt != '0) ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
               if (isolate_i)          r_state <= S_ACTIVE;
               else if (r_occ == '0)   r_state <= S_IDLE;
            end
            default:  r_state <= S_IDLE;
         endcase

         r_proto_err <= w_w_hs && (w_last_i != w_last_beat);

         if (w_w_hs) begin
            r_cnt[r_w_ptr] <= r_cnt[r_w_ptr] + 8'd1;
            if (w_last_beat) r_wdone[r_w_ptr] <= 1'b1;
         end
         if (w_w_adv) r_w_ptr <= f_next(r_w_ptr);

         if (w_pop) begin
            r_wdone[r_b_ptr] <= 1'b0;
            r_b_ptr          <= f_next(r_b_ptr);
         end

         // Push slot can never alias b_ptr or w_ptr's live entry, so it wins last.
         if (w_push) begin
            r_id[r_wr_ptr]    <= w_push_pend ? pend_id_i  : aw_id_i;
            r_len[r_wr_ptr]   <= w_push_pend ? pend_len_i : aw_len_i;
            r_cnt[r_wr_ptr]   <= 8'd0;
            r_wdone[r_wr_ptr] <= w_push_pend && pend_wdone_i;
            r_wr_ptr          <= f_next(r_wr_ptr);
         end

         r_occ   <= w_occ_nxt;
         r_wpend <= r_wpend + c_OW'(w_push) - c_OW'(w_w_adv);
      end
   end

   assign pend_ready_o = w_pend_ready;
   assign aw_ready_o   = w_aw_ready;
   assign w_ready_o    = w_w_ready;
   assign b_valid_o    = w_b_valid;
   assign b_id_o       = r_id[r_b_ptr];
   assign b_resp_o     = w_b_valid ? 2'b10 : 2'b00;
   assign busy_o       = (r_state != S_IDLE);
   assign proto_err_o  = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_wr_err_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_wr_err_responder
// Summary  : Scoreboard bench for wr_err_responder (queue depth 3).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wr_err_responder;

   localparam int c_MAX = 3;
   localparam int c_IDW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             isolate = 1'b0;
   logic             pend_valid = 1'b0;
   logic             pend_ready;
   logic [c_IDW-1:0] pend_id = '0;
   logic [7:0]       pend_len = '0;
   logic             pend_wdone = 1'b0;
   logic             aw_valid = 1'b0;
   logic             aw_ready;
   logic [c_IDW-1:0] aw_id = '0;
   logic [7:0]       aw_len = '0;
   logic             w_valid = 1'b0;
   logic             w_ready;
   logic             w_last = 1'b0;
   logic             b_valid;
   logic             b_ready = 1'b0;
   logic [c_IDW-1:0] b_id;
   logic [1:0]       b_resp;
   logic             busy;
   logic             proto_err;

   int               n_checks = 0;
   int               n_errors = 0;
   int               n_b      = 0;
   int               n_perr   = 0;
   logic [c_IDW-1:0] sb[$];

   wr_err_responder #(.MaxWrTxns(c_MAX), .IdWidth(c_IDW)) u_dut (
      .clk_i(clk), .rst_i(rst), .isolate_i(isolate),
      .pend_valid_i(pend_valid), .pend_ready_o(pend_ready), .pend_id_i(pend_id),
      .pend_len_i(pend_len), .pend_wdone_i(pend_wdone),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_len_i(aw_len),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .busy_o(busy), .proto_err_o(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every B handshake pops the oldest expected ID.
   always @(negedge clk) begin
      if (proto_err) n_perr++;
      if (b_valid && b_ready) begin
         n_b++;
         check_eq("b_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            check_eq("b_id_order", b_id, sb.pop_front());
            check_eq("b_resp", b_resp, 2'b10);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [c_IDW-1:0] id, input logic [7:0] len);
      bit ok = 0;
      aw_valid = 1'b1; aw_id = id; aw_len = len;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (aw_ready) begin
            ok = 1;
            sb.push_back(id);
            break;
         end
         tick();
      end
      check_eq("aw_accept", ok, 1);
      tick();
      aw_valid = 1'b0;
   endtask

   task automatic send_w(input logic last);
      bit ok = 0;
      w_valid = 1'b1; w_last = last;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (w_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      check_eq("w_accept", ok, 1);
      tick();
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic wait_sb_empty(input int max_cyc);
      int k = 0;
      while (sb.size() != 0 && k < max_cyc) begin
         tick();
         k++;
      end
      check_eq("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int perr0;
      int nb0;

      repeat (2) tick();
      check_eq("rst_aw_ready", aw_ready, 0);
      check_eq("rst_pend_ready", pend_ready, 0);
      check_eq("rst_w_ready", w_ready, 0);
      check_eq("rst_b_valid", b_valid, 0);
      check_eq("rst_b_id", b_id, 0);
      check_eq("rst_b_resp", b_resp, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_proto_err", proto_err, 0);
      rst = 1'b0;
      tick();
      check_eq("idle_busy", busy, 0);

      // Minimum latency: AW at N, W at N+1, B at N+2, then held stable.
      isolate = 1'b1;
      tick();
      check_eq("active_busy", busy, 1);
      aw_valid = 1'b1; aw_id = 4'd3; aw_len = 8'd0;
      @(negedge clk);
      check_eq("aw_ready_first", aw_ready, 1);
      sb.push_back(4'd3);
      tick();
      aw_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1;
      @(negedge clk);
      check_eq("w_ready_n1", w_ready, 1);
      check_eq("b_valid_n1", b_valid, 0);
      tick();
      w_valid = 1'b0; w_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("b_hold_valid", b_valid, 1);
         check_eq("b_hold_id", b_id, 3);
         check_eq("b_hold_resp", b_resp, 2'b10);
         tick();
      end
      b_ready = 1'b1;
      wait_sb_empty(20);

      // Orphans take priority over a waiting AW; responses stay in push order.
      aw_valid = 1'b1; aw_id = 4'd5; aw_len = 8'd1;
      pend_valid = 1'b1; pend_id = 4'd1; pend_len = 8'd0; pend_wdone = 1'b1;
      @(negedge clk);
      check_eq("aw_stall_pend0", aw_ready, 0);
      check_eq("pend_ready0", pend_ready, 1);
      sb.push_back(4'd1);
      tick();
      pend_id = 4'd2; pend_len = 8'd3; pend_wdone = 1'b0;
      @(negedge clk);
      check_eq("aw_stall_pend1", aw_ready, 0);
      sb.push_back(4'd2);
      tick();
      pend_valid = 1'b0;
      @(negedge clk);
      check_eq("aw_after_pend", aw_ready, 1);
      sb.push_back(4'd5);
      tick();
      aw_valid = 1'b0;
      for (int i = 0; i < 4; i++) send_w(i == 3);
      for (int i = 0; i < 2; i++) send_w(i == 1);
      wait_sb_empty(40);

      // Full queue: pop frees the slot only on the following cycle.
      b_ready = 1'b0;
      send_aw(4'd8, 8'd0);
      send_aw(4'd9, 8'd0);
      send_aw(4'd10, 8'd0);
      for (int i = 0; i < 3; i++) send_w(1'b1);
      aw_valid = 1'b1; aw_id = 4'd11; aw_len = 8'd0;
      @(negedge clk);
      check_eq("full_aw_ready", aw_ready, 0);
      check_eq("full_pend_ready", pend_ready, 0);
      check_eq("full_b_valid", b_valid, 1);
      tick();
      b_ready = 1'b1;
      @(negedge clk);
      check_eq("aw_ready_same_pop", aw_ready, 0);
      tick();
      b_ready = 1'b0;
      @(negedge clk);
      check_eq("aw_ready_after_pop", aw_ready, 1);
      sb.push_back(4'd11);
      tick();
      aw_valid = 1'b0;
      send_w(1'b1);
      b_ready = 1'b1;
      wait_sb_empty(30);

      // Pointer wrap over many rounds at a non-power-of-two depth.
      for (int r = 0; r < 10; r++) begin
         int l0 = r % 3;
         int l1 = (r + 1) % 3;
         send_aw(4'(r), 8'(l0));
         send_aw(4'(r + 5), 8'(l1));
         for (int j = 0; j <= l0; j++) send_w(j == l0);
         for (int j = 0; j <= l1; j++) send_w(j == l1);
      end
      wait_sb_empty(60);

      // Early w_last: error pulse once, completion still by beat count.
      perr0 = n_perr;
      b_ready = 1'b0;
      send_aw(4'd6, 8'd2);
      send_w(1'b1);
      @(negedge clk);
      check_eq("b_wait_beat1", b_valid, 0);
      tick();
      send_w(1'b0);
      @(negedge clk);
      check_eq("b_wait_beat2", b_valid, 0);
      tick();
      send_w(1'b1);
      @(negedge clk);
      check_eq("b_after_beat3", b_valid, 1);
      tick();
      check_eq("proto_err_pulses", n_perr - perr0, 1);
      b_ready = 1'b1;
      wait_sb_empty(20);

      // Drain after isolate drops with two entries outstanding.
      b_ready = 1'b0;
      send_aw(4'd12, 8'd0);
      send_aw(4'd13, 8'd0);
      isolate = 1'b0;
      tick();
      aw_valid = 1'b1; aw_id = 4'd14; aw_len = 8'd0;
      @(negedge clk);
      check_eq("drain_aw_ready", aw_ready, 0);
      check_eq("drain_pend_ready", pend_ready, 0);
      check_eq("drain_busy", busy, 1);
      tick();
      aw_valid = 1'b0;
      send_w(1'b1);
      send_w(1'b1);
      b_ready = 1'b1;
      wait_sb_empty(30);
      repeat (3) tick();
      check_eq("drain_idle", busy, 0);

      // Asynchronous reset discards a held B; nothing stale afterwards.
      isolate = 1'b1;
      tick();
      b_ready = 1'b0;
      send_aw(4'd2, 8'd0);
      send_w(1'b1);
      @(negedge clk);
      check_eq("b_before_rst", b_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_b_valid", b_valid, 0);
      check_eq("arst_b_resp", b_resp, 0);
      check_eq("arst_b_id", b_id, 0);
      check_eq("arst_aw_ready", aw_ready, 0);
      check_eq("arst_w_ready", w_ready, 0);
      check_eq("arst_busy", busy, 0);
      sb.delete();
      nb0 = n_b;
      tick();
      rst = 1'b0;
      b_ready = 1'b1;
      repeat (6) tick();
      check_eq("no_stale_b", n_b - nb0, 0);
      check_eq("busy_after_rst", busy, 1);
      isolate = 1'b0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
